// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel word in over valid/ready, shifted out one bit per clock on data/frame.
// Latency: first bit on the edge after accept; done pulses with the last frame bit.
// Optional parity bit enabled by defining SERIAL_WORD_TX_PARITY_EN (frame becomes WIDTH+1 bits).
module serial_word_tx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             data,
  output logic             frame,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  // Gap counter needs at least one bit even when the gap is disabled
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef SERIAL_WORD_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, PARITY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
`endif

  state_t          state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
`ifdef SERIAL_WORD_TX_PARITY_EN
  logic             par;
`endif

  // Only an idle transmitter takes a new word; there is no holding buffer
  assign load_ready = (state == IDLE);

  // Transmit sequencer: all outputs are registered from the state being left
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      data    <= 1'b0;
      frame   <= 1'b0;
      done    <= 1'b0;
      sr      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          data  <= 1'b0;
          frame <= 1'b0;
          if (load_valid) begin
            sr      <= load_data;
            bit_cnt <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par     <= ^load_data;
`endif
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          frame <= 1'b1;
          if (MSB_FIRST) begin
            data <= sr[WIDTH-1];
            sr   <= {sr[WIDTH-2:0], 1'b0};
          end else begin
            data <= sr[0];
            sr   <= {1'b0, sr[WIDTH-1:1]};
          end
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            state <= PARITY;
`else
            done  <= 1'b1;
            state <= (GAP_CYCLES > 0) ? GAP : IDLE;
`endif
          end
        end
`ifdef SERIAL_WORD_TX_PARITY_EN
        PARITY: begin
          data  <= par;
          frame <= 1'b1;
          done  <= 1'b1;
          state <= (GAP_CYCLES > 0) ? GAP : IDLE;
        end
`endif
        GAP: begin
          data  <= 1'b0;
          frame <= 1'b0;
          if (gap_cnt == LAST_GAP) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          data  <= 1'b0;
          frame <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
